// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, flag bundle, default width and
// the checker's state encoding.
package alu_pkg;

   localparam int ALU_WIDTH = 2;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic c;
      logic z;
      logic n;
      logic o;
   } alu_flags_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: (a, b, s) -> expected result and flags.
// Shared between the hardware checker and the ALU bench.
module alu_ref_model
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       s,
   output logic [WIDTH-1:0] y,
   output alu_flags_t       flags
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      y     = '0;
      flags = '0;
      case (alu_op_e'(s))
         OP_ADD: begin
            y       = sum[WIDTH-1:0];
            flags.c = sum[WIDTH];
            flags.o = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            // carry means "no borrow", i.e. a >= b
            y       = diff[WIDTH-1:0];
            flags.c = ~diff[WIDTH];
            flags.o = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         default: y = '0;
      endcase
      flags.z = (y == '0);
      flags.n = y[WIDTH-1];
   end

endmodule

// File: rtl/alu_result_checker.sv
// Response-side ALU checker: recomputes each accepted vector and counts
// mismatches over a fixed-length run. ALU_CHECK_FLAGS_EN adds c/z/n/o to the compare.
module alu_result_checker
   import alu_pkg::*;
#(
   parameter int WIDTH       = ALU_WIDTH,
   parameter int NUM_VECTORS = 16,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       s,
   input  logic [WIDTH-1:0] y,
   input  logic             c,
   input  logic             z,
   input  logic             n,
   input  logic             o,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] first_err_idx
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

   chk_state_e       state;
   logic [CNT_W-1:0] acc_cnt;
   logic [2:1]       vld_pipe;
   logic             accept;
   logic             start_run;

   logic [WIDTH-1:0] s1_a, s1_b, s1_y;
   logic [1:0]       s1_s;
   logic [CNT_W-1:0] s1_idx;
   logic             s2_mis;
   logic [CNT_W-1:0] s2_idx;

   logic [WIDTH-1:0] exp_y;
   alu_flags_t       exp_flags;
   logic             mismatch;

   assign accept    = (state == ST_RUN) && in_valid && in_ready;
   assign start_run = start && ((state == ST_IDLE) || (state == ST_DONE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         acc_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state    <= ST_RUN;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  pass     <= 1'b0;
                  acc_cnt  <= '0;
               end
            end
            ST_RUN: begin
               if (accept) begin
                  acc_cnt <= acc_cnt + 1'b1;
                  if (acc_cnt == LAST_IDX) begin
                     state    <= ST_DRAIN;
                     in_ready <= 1'b0;
                  end
               end
            end
            ST_DRAIN: begin
               // counters already hold the last vector once both stages are empty
               if (vld_pipe == '0) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_s     <= '0;
         s1_y     <= '0;
         s1_idx   <= '0;
         s2_mis   <= 1'b0;
         s2_idx   <= '0;
      end else begin
         vld_pipe <= {vld_pipe[1], accept};
         if (accept) begin
            s1_a   <= a;
            s1_b   <= b;
            s1_s   <= s;
            s1_y   <= y;
            s1_idx <= acc_cnt;
         end
         if (vld_pipe[1]) begin
            s2_mis <= mismatch;
            s2_idx <= s1_idx;
         end
      end
   end

   alu_ref_model #(.WIDTH(WIDTH)) u_ref (
      .a     (s1_a),
      .b     (s1_b),
      .s     (s1_s),
      .y     (exp_y),
      .flags (exp_flags)
   );

`ifdef ALU_CHECK_FLAGS_EN
   alu_flags_t s1_flags;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         s1_flags <= '0;
      else if (accept) s1_flags <= '{c: c, z: z, n: n, o: o};
   end

   assign mismatch = (exp_y != s1_y) || (exp_flags != s1_flags);
`else
   logic unused_flags;

   assign unused_flags = ^{c, z, n, o, exp_flags};
   assign mismatch     = (exp_y != s1_y);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count     <= '0;
         vec_count     <= '0;
         first_err_idx <= '1;
      end else if (start_run) begin
         err_count     <= '0;
         vec_count     <= '0;
         first_err_idx <= '1;
      end else if (vld_pipe[2]) begin
         vec_count <= vec_count + 1'b1;
         if (s2_mis) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            // err_count saturates, so zero only means "no mismatch yet this run"
            if (err_count == '0) first_err_idx <= s2_idx;
         end
      end
   end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: timing-level model of accepted vectors checked
// against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_alu_result_checker;

   localparam int NV = 16;
`ifdef ALU_CHECK_FLAGS_EN
   localparam logic [5:0] MASK  = 6'h3F;
   localparam int         FLAGS = 1;
`else
   localparam logic [5:0] MASK  = 6'h30;
   localparam int         FLAGS = 0;
`endif

   logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
   logic [1:0] a = '0, b = '0, s = '0, y = '0;
   logic c = 1'b0, z = 1'b0, n = 1'b0, o = 1'b0;
   logic in_ready, busy, done, pass;
   logic [7:0] err_count, vec_count, first_err_idx;

   always #5 clk = ~clk;

   alu_result_checker #(.WIDTH(2), .NUM_VECTORS(NV), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .a(a), .b(b), .s(s), .y(y), .c(c), .z(z), .n(n), .o(o),
      .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .vec_count(vec_count), .first_err_idx(first_err_idx)
   );

   int checks = 0, errors = 0;
   int cyc = 0;
   bit started = 0;
   bit chk_en = 0;
   int acc_cyc[$];
   bit acc_mis[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // {y[1:0], c, z, n, o} from plain integer arithmetic
   function automatic logic [5:0] golden(input int ai, input int bi, input int si);
      int r, sa, sb, sr;
      logic [1:0] yy;
      logic cc, oo;
      sa = (ai >= 2) ? ai - 4 : ai;
      sb = (bi >= 2) ? bi - 4 : bi;
      cc = 0; oo = 0; r = 0;
      case (si)
         0: begin r = ai + bi; cc = (r >= 4);   sr = sa + sb; oo = (sr > 1) || (sr < -2); end
         1: begin r = ai - bi; cc = (ai >= bi); sr = sa - sb; oo = (sr > 1) || (sr < -2); end
         2: r = ai & bi;
         default: r = ai | bi;
      endcase
      yy = 2'((r + 4) % 4);
      return {yy, cc, (yy == 2'b00), yy[1], oo};
   endfunction

   function automatic bit model_done();
      return started && acc_cyc.size() == NV && cyc >= acc_cyc[NV-1] + 3;
   endfunction

   task automatic model_clear();
      started = 0;
      acc_cyc.delete();
      acc_mis.delete();
   endtask

   task automatic step(output bit acc);
      bit rdy_b, done_b, m;
      rdy_b  = started && acc_cyc.size() < NV;
      done_b = model_done();
      acc    = rdy_b && in_valid && !rst;
      m      = (golden(a, b, s) & MASK) != ({y, c, z, n, o} & MASK);
      @(posedge clk);
      cyc++;
      if (rst) model_clear();
      else begin
         if (acc) begin
            acc_cyc.push_back(cyc);
            acc_mis.push_back(m);
         end
         if (start && (!started || done_b)) begin
            model_clear();
            started = 1;
         end
      end
      #1;
      start = 1'b0;
   endtask

   task automatic send(input int va, input int vb, input int vs, input logic [5:0] resp,
                       input int gap);
      bit acc;
      int g;
      in_valid = 1'b0;
      repeat (gap) step(acc);
      a = 2'(va); b = 2'(vb); s = 2'(vs);
      {y, c, z, n, o} = resp;
      in_valid = 1'b1;
      g = 0;
      do begin step(acc); g++; end while (!acc && g < 20);
      if (!acc) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic run_start();
      bit acc;
      start = 1'b1;
      step(acc);
   endtask

   task automatic wait_done();
      bit acc;
      int g;
      in_valid = 1'b0;
      g = 0;
      while (done !== 1'b1 && g < 12) begin step(acc); g++; end
      chk("done_reached", int'(done), 1);
      if (acc_cyc.size() == NV) chk("done_latency", cyc - acc_cyc[NV-1], 3);
   endtask

   // every cycle: DUT outputs versus the accept-timeline model
   always @(negedge clk) begin
      if (chk_en) begin
         int e_vec, e_err, e_fei;
         bit e_done, e_rdy;
         e_vec = 0; e_err = 0; e_fei = 255;
         foreach (acc_cyc[i]) begin
            if (acc_cyc[i] <= cyc - 2) begin
               e_vec++;
               if (acc_mis[i]) begin
                  if (e_fei == 255) e_fei = i;
                  if (e_err < 255) e_err++;
               end
            end
         end
         e_done = model_done();
         e_rdy  = started && acc_cyc.size() < NV;
         chk("in_ready", int'(in_ready), int'(e_rdy));
         chk("busy", int'(busy), int'(started && !e_done));
         chk("done", int'(done), int'(e_done));
         chk("pass", int'(pass), int'(e_done && e_err == 0));
         chk("vec_count", int'(vec_count), e_vec);
         chk("err_count", int'(err_count), e_err);
         chk("first_err_idx", int'(first_err_idx), e_fei);
      end
   end

   initial begin
      bit acc;
      logic [5:0] r;

      chk("model_add_1_1", int'(golden(1, 1, 0)), int'(6'b10_0011));
      chk("model_sub_0_1", int'(golden(0, 1, 1)), int'(6'b11_0010));
      chk("model_and_3_2", int'(golden(3, 2, 2)), int'(6'b10_0010));
      chk("model_add_3_1", int'(golden(3, 1, 0)), int'(6'b00_1100));

      rst = 1'b1;
      step(acc);
      step(acc);
      rst = 1'b0;
      chk_en = 1;
      chk("rst_first_err_idx", int'(first_err_idx), 255);

      // reset mid-run after 5 accepts
      run_start();
      for (int i = 0; i < 5; i++) send(i >> 2, i & 3, 0, golden(i >> 2, i & 3, 0), 0);
      rst = 1'b1;
      model_clear();
      #1;
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_in_ready", int'(in_ready), 0);
      chk("async_rst_vec_count", int'(vec_count), 0);
      chk("async_rst_fei", int'(first_err_idx), 255);
      step(acc);
      rst = 1'b0;

      // clean ADD sweep
      run_start();
      for (int i = 0; i < NV; i++) send(i >> 2, i & 3, 0, golden(i >> 2, i & 3, 0), 0);
      wait_done();
      chk("sweep_pass", int'(pass), 1);
      chk("sweep_err", int'(err_count), 0);
      chk("sweep_vec", int'(vec_count), 16);
      chk("sweep_fei", int'(first_err_idx), 255);

      // vector 5 (01+01) reported y=00
      run_start();
      for (int i = 0; i < NV; i++) begin
         r = golden(i >> 2, i & 3, 0);
         if (i == 5) r[5:4] = 2'b00;
         send(i >> 2, i & 3, 0, r, 0);
      end
      wait_done();
      chk("y_err_count", int'(err_count), 1);
      chk("y_err_fei", int'(first_err_idx), 5);
      chk("y_err_pass", int'(pass), 0);

      // SUB 00-01 with a wrong carry only
      run_start();
      send(0, 1, 1, 6'b11_1010, 0);
      for (int i = 1; i < NV; i++) send(i >> 2, i & 3, 0, golden(i >> 2, i & 3, 0), 0);
      wait_done();
      chk("carry_err_count", int'(err_count), FLAGS);

      // in_valid in IDLE, start mid-RUN, in_valid toggling
      rst = 1'b1;
      model_clear();
      step(acc);
      rst = 1'b0;
      a = 2'd1; b = 2'd2; s = 2'd0; {y, c, z, n, o} = 6'b00_0000;
      in_valid = 1'b1;
      repeat (3) step(acc);
      start = 1'b1;
      step(acc);
      for (int i = 0; i < NV; i++) begin
         if (i == 7) start = 1'b1;
         send(i & 3, i >> 2, 1, golden(i & 3, i >> 2, 1), 1);
      end
      wait_done();
      chk("toggle_vec", int'(vec_count), 16);
      chk("toggle_err", int'(err_count), 0);

      // restart from DONE; vector 3 is AND 11&10 reported as 11
      run_start();
      chk("restart_clear_err", int'(err_count), 0);
      chk("restart_clear_vec", int'(vec_count), 0);
      for (int i = 0; i < NV; i++) begin
         if (i == 3) send(3, 2, 2, 6'b11_0010, 0);
         else        send(i >> 2, i & 3, 3, golden(i >> 2, i & 3, 3), 0);
      end
      wait_done();
      chk("and_err_count", int'(err_count), 1);
      chk("and_err_fei", int'(first_err_idx), 3);

      // randomized runs
      for (int run = 0; run < 6; run++) begin
         run_start();
         for (int i = 0; i < NV; i++) begin
            int va, vb, vs;
            va = int'($urandom_range(0, 3));
            vb = int'($urandom_range(0, 3));
            vs = int'($urandom_range(0, 3));
            r = golden(va, vb, vs);
            if ($urandom_range(0, 3) == 0) r = r ^ 6'($urandom_range(1, 63));
            if ($urandom_range(0, 7) == 0) start = 1'b1;
            send(va, vb, vs, r, int'($urandom_range(0, 2)));
         end
         wait_done();
      end

      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
